// File: rtl/pc_pkg.sv
// Shared definitions for the PC generator: FSM state encoding and common constants.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [63:0] ZERO_WORD = 64'h0;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// synchronous write of taken-branch targets from EX.
module pc_btb
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INST_BYTES  = 4,
    parameter int BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic [ADDR_W-1:0] target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target
);

    localparam int OFF_W = $clog2(INST_BYTES);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_en;

    assign rd_idx = lookup_pc[OFF_W +: IDX_W];
    assign rd_tag = lookup_pc[ADDR_W-1 -: TAG_W];
    assign wr_idx = upd_pc[OFF_W +: IDX_W];
    assign wr_tag = upd_pc[ADDR_W-1 -: TAG_W];
    assign wr_en  = !rst && rdy && upd_valid;

    // Reads see the array before this edge's write, so a same-index update is invisible until next cycle.
    assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign target = tgt_q[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= ENABLE;
        end
    end

    // NOTE: tag/target arrays are not reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= upd_target;
        end
    end

    generate
        if (OFF_W > 0) begin : g_off
            logic unused_off;
            assign unused_off = ^{lookup_pc[OFF_W-1:0], upd_pc[OFF_W-1:0]};
        end
    endgenerate

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with redirect handling and HOLD state for in-flight fetches.
// Optional BTB prediction is built when macro PC_BTB_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INST_BYTES  = 4,
    parameter int                BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              fetch_busy_i,
    input  logic              fetch_done_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              pred_taken_o,
    output logic              flush_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pending_q;
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_target;
    logic [ADDR_W-1:0] seq_next;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              hold_exit;

`ifdef PC_BTB_EN
    pc_btb #(
        .ADDR_W      (ADDR_W),
        .INST_BYTES  (INST_BYTES),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .lookup_pc  (pc_q),
        .hit        (btb_hit),
        .target     (btb_target),
        .upd_valid  (upd_valid_i),
        .upd_pc     (upd_pc_i),
        .upd_target (upd_target_i)
    );
    assign seq_next = pred_taken_o ? align(btb_target) : pc_q + PC_INC;
`else
    logic unused_upd;
    assign unused_upd = ^{upd_valid_i, upd_pc_i, upd_target_i};
    assign btb_hit    = DISABLE;
    assign btb_target = ADDR_W'(ZERO_WORD);
    assign seq_next   = pc_q + PC_INC;
`endif

    assign redirect_aligned = align(redirect_pc_i);
    assign hold_exit        = fetch_done_i || !fetch_busy_i;

    assign pc_o         = pc_q;
    assign pc_valid_o   = !rst && rdy && (state_q == ST_RUN) && !stall_i;
    assign pred_taken_o = !rst && btb_hit;
    // A redirect is only accepted once the FSM has left INIT.
    assign flush_o      = !rst && rdy && redirect_valid_i && (state_q != ST_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            state_q   <= ST_INIT;
            pending_q <= ADDR_W'(ZERO_WORD);
        end else if (rdy) begin
            unique case (state_q)
                ST_INIT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (redirect_valid_i) begin
                        if (fetch_busy_i) begin
                            pending_q <= redirect_aligned;
                            state_q   <= ST_HOLD;
                        end else begin
                            pc_q <= redirect_aligned;
                        end
                    end else if (!stall_i && fetch_done_i) begin
                        pc_q <= seq_next;
                    end
                end
                ST_HOLD: begin
                    // The newest redirect wins, even on the cycle the fetch completes.
                    if (redirect_valid_i) begin
                        pending_q <= redirect_aligned;
                    end
                    if (hold_exit) begin
                        pc_q    <= redirect_valid_i ? redirect_aligned : pending_q;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scenario-driven bench for pc_gen: expected PCs are queued when stimulus is applied
// and compared after the clock edge that should produce them.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, rdy, stall_i, redirect_valid_i, fetch_busy_i, fetch_done_i;
    logic [31:0] redirect_pc_i, upd_pc_i, upd_target_i;
    logic        upd_valid_i;
    logic [31:0] pc_o;
    logic        pc_valid_o, pred_taken_o, flush_o;

    typedef struct {
        string       name;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    pc_gen dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_busy_i     (fetch_busy_i),
        .fetch_done_i     (fetch_done_i),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_target_i     (upd_target_i),
        .pc_o             (pc_o),
        .pc_valid_o       (pc_valid_o),
        .pred_taken_o     (pred_taken_o),
        .flush_o          (flush_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; stall_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
        fetch_busy_i = 0; fetch_done_i = 0; upd_valid_i = 0; upd_pc_i = 0; upd_target_i = 0;
    endtask

    // Moves a RUN-state DUT to a known PC via an immediate redirect (no compare).
    task automatic goto_pc(input logic [31:0] pc);
        idle();
        redirect_valid_i = 1; redirect_pc_i = pc;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; redirect_valid_i = 1; redirect_pc_i = 32'h500; fetch_done_i = 1;
        sb_q.push_back('{name:"reset_pc", pc:32'h0});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        checks++;
        if ({pc_valid_o, flush_o, pred_taken_o} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs: valid/flush/pred=%b expected 000", {pc_valid_o, flush_o, pred_taken_o});
        end
        idle(); fetch_done_i = 1; #1;
        checks++;
        if (pc_valid_o !== 1'b0) begin errors++; $display("FAIL init_valid: pc_valid_o=%b expected 0", pc_valid_o); end
        sb_q.push_back('{name:"init_to_run", pc:32'h0});
        sb_q.push_back('{name:"seq_4", pc:32'h4});
        sb_q.push_back('{name:"seq_8", pc:32'h8});
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb_q.pop_front(); checks++;
            if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
            checks++;
            if (pc_valid_o !== 1'b1) begin errors++; $display("FAIL %s_valid: pc_valid_o=%b expected 1", e.name, pc_valid_o); end
        end
    endtask

    task automatic test_redirect();
        goto_pc(32'h100);
        redirect_valid_i = 1; redirect_pc_i = 32'h2000; #1;
        checks++;
        if (flush_o !== 1'b1) begin errors++; $display("FAIL redirect_flush: flush_o=%b expected 1", flush_o); end
        sb_q.push_back('{name:"redirect_2000", pc:32'h2000});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        redirect_pc_i = 32'h2007;
        sb_q.push_back('{name:"redirect_aligned", pc:32'h2004});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        idle();
    endtask

    task automatic test_hold();
        goto_pc(32'h100);
        fetch_busy_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h3000; #1;
        checks++;
        if (flush_o !== 1'b1) begin errors++; $display("FAIL hold_flush: flush_o=%b expected 1", flush_o); end
        sb_q.push_back('{name:"hold_enter", pc:32'h100});
        sb_q.push_back('{name:"hold_wait", pc:32'h100});
        for (int i = 0; i < 2; i++) begin
            tick();
            redirect_valid_i = 0; #1;
            e = sb_q.pop_front(); checks++;
            if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
            checks++;
            if ({pc_valid_o, flush_o} !== 2'b00) begin
                errors++; $display("FAIL %s_status: valid/flush=%b expected 00", e.name, {pc_valid_o, flush_o});
            end
        end
        fetch_done_i = 1; #1;
        checks++;
        if (flush_o !== 1'b0) begin errors++; $display("FAIL hold_exit_flush: flush_o=%b expected 0", flush_o); end
        sb_q.push_back('{name:"hold_load", pc:32'h3000});
        tick();
        idle(); #1;
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        checks++;
        if (pc_valid_o !== 1'b1) begin errors++; $display("FAIL hold_load_valid: pc_valid_o=%b expected 1", pc_valid_o); end
        // Overwrite pending twice; the last one coincides with fetch completion.
        fetch_busy_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h4000;
        tick();
        redirect_pc_i = 32'h5000; #1;
        checks++;
        if (flush_o !== 1'b1) begin errors++; $display("FAIL hold_overwrite_flush: flush_o=%b expected 1", flush_o); end
        tick();
        redirect_pc_i = 32'h6000; fetch_done_i = 1;
        sb_q.push_back('{name:"hold_newest", pc:32'h6000});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        idle();
    endtask

    task automatic test_wrap_stall();
        goto_pc(32'hFFFF_FFFC);
        fetch_done_i = 1;
        sb_q.push_back('{name:"wrap", pc:32'h0});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        goto_pc(32'hFFFF_FFFC);
        fetch_done_i = 1; stall_i = 1; #1;
        checks++;
        if (pc_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid: pc_valid_o=%b expected 0", pc_valid_o); end
        sb_q.push_back('{name:"stall_hold", pc:32'hFFFF_FFFC});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        redirect_valid_i = 1; redirect_pc_i = 32'h80;
        sb_q.push_back('{name:"redirect_over_stall", pc:32'h80});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        idle();
    endtask

    task automatic test_rdy();
        goto_pc(32'h700);
        rdy = 0; redirect_valid_i = 1; redirect_pc_i = 32'h900; fetch_done_i = 1; #1;
        checks++;
        if ({pc_valid_o, flush_o} !== 2'b00) begin
            errors++; $display("FAIL rdy_low_status: valid/flush=%b expected 00", {pc_valid_o, flush_o});
        end
        sb_q.push_back('{name:"rdy_freeze", pc:32'h700});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        idle();
    endtask

    task automatic test_btb();
        logic exp_pred;
        logic [31:0] exp_next;
`ifdef PC_BTB_EN
        exp_pred = 1'b1; exp_next = 32'h800;
`else
        exp_pred = 1'b0; exp_next = 32'h44;
`endif
        upd_valid_i = 1; upd_pc_i = 32'h40; upd_target_i = 32'h800;
        tick();
        idle();
        goto_pc(32'h80);
        #1;
        checks++;
        if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL btb_tag_miss: pred_taken_o=%b expected 0", pred_taken_o); end
        goto_pc(32'h40);
        #1;
        checks++;
        if (pred_taken_o !== exp_pred) begin errors++; $display("FAIL btb_pred: pred_taken_o=%b expected %b", pred_taken_o, exp_pred); end
        // Same-index update in the lookup cycle must not affect this prediction.
        fetch_done_i = 1; upd_valid_i = 1; upd_pc_i = 32'h40; upd_target_i = 32'h900;
        sb_q.push_back('{name:"btb_next", pc:exp_next});
        tick();
        idle();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
    endtask

    task automatic test_reset_in_hold();
        goto_pc(32'h100);
        fetch_busy_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h3000;
        tick();
        idle(); fetch_busy_i = 1;
        rst = 1;
        sb_q.push_back('{name:"reset_in_hold", pc:32'h0});
        tick();
        e = sb_q.pop_front(); checks++;
        if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        idle(); fetch_done_i = 1;
        sb_q.push_back('{name:"post_reset_init", pc:32'h0});
        sb_q.push_back('{name:"post_reset_seq", pc:32'h4});
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb_q.pop_front(); checks++;
            if (pc_o !== e.pc) begin errors++; $display("FAIL %s: pc_o=%h expected %h", e.name, pc_o, e.pc); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_hold();
        test_wrap_stall();
        test_rdy();
        test_btb();
        test_reset_in_hold();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
